jtag_tap_controller: RTL and testbench
======================================

// Module: jtag_tap_controller
// PURPOSE
//  IEEE 1149.1-style TAP controller driving the boundary-scan cell (BSC) chain.
//  Decodes TMS into the 16-state TAP FSM and holds the instruction register (IR).
//  Produces ShiftDR/ClockDR/UpdateDR/Mode controls and the BSR serial input.
//  Muxes TDO from IR, bypass, BSR or IDCODE. Single-clock design: ClockDR and
//  UpdateDR are one-cycle clock-enable strobes, not gated clocks.
// PARAMETERS
//  IR_WIDTH   4             instruction register width (>=2)
//  IDCODE_VAL 32'h1000_0001 device ID, LSB must be 1 (used only with IDCODE_EN)
// PORTS
//  Clock      in   1         TCK; all state changes on posedge
//  Reset      in   1         synchronous, active-high; forces Test-Logic-Reset
//  TMS        in   1         test mode select, sampled on posedge
//  TDI        in   1         test data in
//  TDO        out  1         test data out (combinational from selected reg LSB)
//  TDO_En     out  1         1 in Shift-DR or Shift-IR, else 0
//  ShiftIn    out  1         serial input to first BSC (= TDI)
//  ShiftOut   in   1         serial output of last BSC
//  ShiftDR    out  1         BSC shift/capture mux select
//  ClockDR    out  1         BSC capture/shift enable strobe
//  UpdateDR   out  1         BSC update-latch enable strobe
//  Mode       out  1         BSC output mux: 1 = drive from update latch (test)
//  State      out  4         current TAP state encoding (debug)
//  Instr      out  IR_WIDTH  active (updated) instruction
// BEHAVIOUR
//  State encoding: TLR=F RTI=C SelDR=7 CapDR=6 ShDR=2 Ex1DR=1 PauDR=3 Ex2DR=0
//   UpdDR=5 SelIR=4 CapIR=E ShIR=A Ex1IR=9 PauIR=B Ex2IR=8 UpdIR=D.
//  Transitions per 1149.1 on each posedge from TMS; five TMS=1 reach TLR from any state.
//  Reset=1: State=F, IR shift reg=0, Instr=IDCODE (IDCODE_EN) else BYPASS, bypass=0.
//   Reset wins over TMS and aborts any scan mid-operation; no UpdateDR pulse.
//  Outputs at reset: TDO=0 TDO_En=0 ShiftDR=0 ClockDR=0 UpdateDR=0 Mode=0.
//  Entering TLR by TMS has the same effect on Instr as Reset.
//  Opcodes (IR_WIDTH=4): EXTEST=0 SAMPLE=1 IDCODE=2 BYPASS=all-ones.
//   Unknown opcodes, or IDCODE without IDCODE_EN, behave as BYPASS.
//  IR: in CapIR load {0..,2'b01}; in ShIR shift right, TDI into MSB, TDO=IR[0].
//   Instr <= IR shift reg on the clock leaving UpdIR (visible in next state).
//  BSR selected (EXTEST/SAMPLE): ShiftDR=1 in state ShDR, else 0.
//   ClockDR=1 in CapDR and ShDR; UpdateDR=1 in UpdDR only (exactly 1 cycle).
//   TDO=ShiftOut in ShDR.
//  Bypass selected: 1-bit reg, 0 in CapDR, TDI in ShDR; TDO=bypass; 1-cycle delay.
//   ShiftDR, ClockDR and UpdateDR stay 0.
//  Mode=1 iff Instr==EXTEST; it changes only when Instr changes.
//  Pause/Exit states: all strobes 0; shift registers hold.
//  ShiftIn=TDI always. TDO=0 when TDO_En=0.
// CONFIGURATION
//  JTAG_IDCODE_EN defined: 32-bit ID reg; CapDR loads IDCODE_VAL; ShDR shifts
//   right with TDI into MSB; TDO=ID[0]. Reset/TLR select IDCODE.
//  JTAG_IDCODE_EN undefined: no ID reg; opcode 2 decodes as BYPASS.
//   Reset/TLR select BYPASS.
// TESTING
//  1 Reset=1 for 2 cycles -> State=F, Instr=BYPASS (IDCODE if JTAG_IDCODE_EN),
//    Mode=0, all strobes 0.
//  2 From ShDR, apply TMS=1 x5 -> State=F; with TMS=0 held in ShDR, Reset=1
//    -> State=F next cycle, UpdateDR never pulses.
//  3 IR scan, TMS 0,1,1,0,0 then shift 4'h0 LSB-first, exit via UpdIR
//    -> CapIR TDO bits 1,0,0,0; Instr=0 and Mode=1 the cycle after UpdIR.
//  4 EXTEST, DR scan of 8 bits -> ClockDR high 1 cycle in CapDR + 8 in ShDR;
//    ShiftDR high 8 cycles; UpdateDR one pulse; TDO mirrors ShiftOut.
//  5 BYPASS, shift TDI=1,0,1,1 -> TDO=0 (captured),1,0,1;
//    ShiftDR, ClockDR and UpdateDR stay 0.
//  6 JTAG_IDCODE_EN, after reset, DR scan of 32 bits -> TDO yields IDCODE_VAL
//    LSB-first (first bit 1).

Source files
------------

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction register and
// boundary-scan cell controls. Define JTAG_IDCODE_EN to build the 32-bit IDCODE register.
module jtag_tap_controller #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_En,
  output logic                ShiftIn,
  input  logic                ShiftOut,
  output logic                ShiftDR,
  output logic                ClockDR,
  output logic                UpdateDR,
  output logic                Mode,
  output logic [3:0]          State,
  output logic [IR_WIDTH-1:0] Instr
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
    PAUDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
    SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
    PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

`ifdef JTAG_IDCODE_EN
  localparam logic ID_BUILD = 1'b1;
`else
  localparam logic ID_BUILD = 1'b0;
`endif
  // An ID value with LSB 0 is not a legal IDCODE, so IDCODE then falls back to BYPASS.
  localparam logic ID_PRESENT = ID_BUILD & IDCODE_VAL[0];
  localparam logic [IR_WIDTH-1:0] INSTR_RESET = ID_PRESENT ? OP_IDCODE : OP_BYPASS;

  tap_state_e          state, state_next;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] active_ir;
  logic                bypass_reg;
  logic                id_lsb;
  logic                sel_bsr, sel_id, sel_byp;

  assign State   = state;
  assign Instr   = active_ir;
  assign ShiftIn = TDI;
  assign Mode    = (active_ir == OP_EXTEST);

  assign sel_bsr = (active_ir == OP_EXTEST) || (active_ir == OP_SAMPLE);
  assign sel_id  = ID_PRESENT && (active_ir == OP_IDCODE);
  assign sel_byp = !sel_bsr && !sel_id;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= TLR;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      TLR:   state_next = TMS ? TLR   : RTI;
      RTI:   state_next = TMS ? SELDR : RTI;
      SELDR: state_next = TMS ? SELIR : CAPDR;
      CAPDR: state_next = TMS ? EX1DR : SHDR;
      SHDR:  state_next = TMS ? EX1DR : SHDR;
      EX1DR: state_next = TMS ? UPDDR : PAUDR;
      PAUDR: state_next = TMS ? EX2DR : PAUDR;
      EX2DR: state_next = TMS ? UPDDR : SHDR;
      UPDDR: state_next = TMS ? SELDR : RTI;
      SELIR: state_next = TMS ? TLR   : CAPIR;
      CAPIR: state_next = TMS ? EX1IR : SHIR;
      SHIR:  state_next = TMS ? EX1IR : SHIR;
      EX1IR: state_next = TMS ? UPDIR : PAUIR;
      PAUIR: state_next = TMS ? EX2IR : PAUIR;
      EX2IR: state_next = TMS ? UPDIR : SHIR;
      UPDIR: state_next = TMS ? SELDR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Output decode
  always_comb begin
    TDO      = 1'b0;
    TDO_En   = 1'b0;
    ShiftDR  = 1'b0;
    ClockDR  = 1'b0;
    UpdateDR = 1'b0;
    case (state)
      SHIR: begin
        TDO_En = 1'b1;
        TDO    = ir_sr[0];
      end
      SHDR: begin
        TDO_En  = 1'b1;
        ShiftDR = sel_bsr;
        ClockDR = sel_bsr;
        if (sel_bsr)     TDO = ShiftOut;
        else if (sel_id) TDO = id_lsb;
        else             TDO = bypass_reg;
      end
      CAPDR:   ClockDR  = sel_bsr;
      UPDDR:   UpdateDR = sel_bsr;
      default: ;
    endcase
  end

  // Instruction shift register and active instruction
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_sr     <= '0;
      active_ir <= INSTR_RESET;
    end else begin
      if (state == CAPIR)     ir_sr <= IR_WIDTH'(1);
      else if (state == SHIR) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};

      if (state_next == TLR)  active_ir <= INSTR_RESET;
      else if (state == UPDIR) active_ir <= ir_sr;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bypass_reg <= 1'b0;
    end else if (sel_byp) begin
      if (state == CAPDR)     bypass_reg <= 1'b0;
      else if (state == SHDR) bypass_reg <= TDI;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      id_sr <= IDCODE_VAL;
    end else if (sel_id) begin
      if (state == CAPDR)     id_sr <= IDCODE_VAL;
      else if (state == SHDR) id_sr <= {TDI, id_sr[31:1]};
    end
  end

  assign id_lsb = id_sr[0];
`else
  assign id_lsb = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized bench for jtag_tap_controller: a queue-based TAP model is checked
// every cycle, plus directed scans with hand-computed expectations.
module tb_jtag_tap_controller;
  localparam int          IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic           Clock, Reset, TMS, TDI, ShiftOut;
  logic           TDO, TDO_En, ShiftIn, ShiftDR, ClockDR, UpdateDR, Mode;
  logic [3:0]     State;
  logic [IRW-1:0] Instr;

  jtag_tap_controller #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV)) dut (
    .Clock(Clock), .Reset(Reset), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_En(TDO_En),
    .ShiftIn(ShiftIn), .ShiftOut(ShiftOut), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
    .UpdateDR(UpdateDR), .Mode(Mode), .State(State), .Instr(Instr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TAP graph as lookup tables indexed by state code: next state for TMS=0 / TMS=1
  int nxt0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  localparam int S_SHDR = 2, S_CAPDR = 6, S_UPDDR = 5, S_TLR = 15, S_RTI = 12;
  localparam int S_SHIR = 10, S_CAPIR = 14, S_UPDIR = 13;

  int m_state;
  int m_instr;
  bit ir_q[$];
  bit dr_q[$];
  bit model_valid = 1'b0;

  function automatic int instr_default();
    return ID_EN ? 2 : (1 << IRW) - 1;
  endfunction

  // 0 = boundary-scan register, 1 = IDCODE, 2 = bypass
  function automatic int dr_kind(input int op);
    if (op == 0 || op == 1) return 0;
    if (op == 2 && ID_EN)  return 1;
    return 2;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      model_valid = 1'b1;
      m_state = S_TLR;
      m_instr = instr_default();
      ir_q = {};
      for (int i = 0; i < IRW; i++) ir_q.push_back(1'b0);
      dr_q = {};
    end else if (model_valid) begin
      int ns;
      ns = TMS ? nxt1[m_state] : nxt0[m_state];
      case (m_state)
        S_CAPIR: begin
          ir_q = {};
          ir_q.push_back(1'b1);
          for (int i = 1; i < IRW; i++) ir_q.push_back(1'b0);
        end
        S_SHIR: begin
          ir_q.push_back(TDI);
          void'(ir_q.pop_front());
        end
        S_UPDIR: begin
          int v;
          v = 0;
          foreach (ir_q[i]) v |= int'(ir_q[i]) << i;
          m_instr = v;
        end
        S_CAPDR: begin
          dr_q = {};
          if (dr_kind(m_instr) == 2) dr_q.push_back(1'b0);
          else if (dr_kind(m_instr) == 1)
            for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
        end
        S_SHDR: begin
          if (dr_q.size() > 0) begin
            dr_q.push_back(TDI);
            void'(dr_q.pop_front());
          end
        end
        default: ;
      endcase
      if (ns == S_TLR) m_instr = instr_default();
      m_state = ns;
    end
  end

  int cnt_cdr, cnt_sdr, cnt_udr;

  always @(negedge Clock) begin
    if (model_valid) begin
      int  k;
      bit  e_tdo;
      k = dr_kind(m_instr);
      e_tdo = 1'b0;
      if (m_state == S_SHIR) e_tdo = ir_q[0];
      else if (m_state == S_SHDR) e_tdo = (k == 0) ? ShiftOut : (dr_q.size() > 0 ? dr_q[0] : 1'b0);
      chk("State",    int'(State),    m_state);
      chk("Instr",    int'(Instr),    m_instr);
      chk("TDO",      int'(TDO),      int'(e_tdo));
      chk("TDO_En",   int'(TDO_En),   int'(m_state == S_SHDR || m_state == S_SHIR));
      chk("ShiftIn",  int'(ShiftIn),  int'(TDI));
      chk("ShiftDR",  int'(ShiftDR),  int'(k == 0 && m_state == S_SHDR));
      chk("ClockDR",  int'(ClockDR),  int'(k == 0 && (m_state == S_SHDR || m_state == S_CAPDR)));
      chk("UpdateDR", int'(UpdateDR), int'(k == 0 && m_state == S_UPDDR));
      chk("Mode",     int'(Mode),     int'(m_instr == 0));
    end
    if (ClockDR === 1'b1)  cnt_cdr++;
    if (ShiftDR === 1'b1)  cnt_sdr++;
    if (UpdateDR === 1'b1) cnt_udr++;
  end

  // Inputs change 1 time unit after the falling edge; returns just after the next falling edge.
  task automatic cyc(input bit rst, input bit tms, input bit tdi);
    Reset = rst; TMS = tms; TDI = tdi; ShiftOut = 1'($urandom);
    @(negedge Clock);
    #1;
  endtask

  task automatic clr_counts();
    cnt_cdr = 0; cnt_sdr = 0; cnt_udr = 0;
  endtask

  // Starts and ends in Run-Test/Idle; returns the bits seen on TDO while shifting.
  task automatic ir_scan(input logic [IRW-1:0] op, output logic [IRW-1:0] seen);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < IRW; i++) begin
      seen[i] = TDO;
      cyc(0, i == IRW - 1, op[i]);
    end
    cyc(0, 1, 0); cyc(0, 0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      cyc(0, i == n - 1, din[i]);
    end
    cyc(0, 1, 0); cyc(0, 0, 0);
  endtask

  initial begin
    logic [IRW-1:0] irs;
    logic [31:0]    dout;
    Reset = 1'b1; TMS = 1'b0; TDI = 1'b0; ShiftOut = 1'b0;
    clr_counts();

    // Reset state
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk("rst_state", int'(State), 'hF);
    chk("rst_instr", int'(Instr), ID_EN ? 2 : 'hF);
    chk("rst_mode",  int'(Mode), 0);
    chk("rst_strobes", int'({ShiftDR, ClockDR, UpdateDR, TDO_En, TDO}), 0);

`ifdef JTAG_IDCODE_EN
    cyc(0, 0, 0);
    dr_scan(32, $urandom, dout);
    chk("idcode_scan", int'(dout), int'(IDV));
    chk("idcode_lsb", int'(dout[0]), 1);
`else
    cyc(0, 0, 0);
`endif

    // Load EXTEST: capture pattern 1,0,0,0 on TDO
    ir_scan('0, irs);
    chk("capir_bits", int'(irs), 1);
    chk("extest_instr", int'(Instr), 0);
    chk("extest_mode", int'(Mode), 1);

    // EXTEST 8-bit DR scan strobes
    clr_counts();
    dr_scan(8, 32'h5A, dout);
    chk("extest_clockdr", cnt_cdr, 9);
    chk("extest_shiftdr", cnt_sdr, 8);
    chk("extest_updatedr", cnt_udr, 1);

    // Reset aborts a scan held in Shift-DR without an UpdateDR pulse
    cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("in_shdr", int'(State), 2);
    clr_counts();
    cyc(1, 0, 0);
    chk("abort_state", int'(State), 'hF);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("abort_no_upd", cnt_udr, 0);
    chk("abort_mode", int'(Mode), 0);

    // Five TMS=1 from Shift-DR reach Test-Logic-Reset
    cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("shdr_again", int'(State), 2);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    chk("tms5_state", int'(State), 'hF);

    // BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1, no BSC strobes
    cyc(0, 0, 0);
    ir_scan('1, irs);
    chk("bypass_instr", int'(Instr), 'hF);
    clr_counts();
    dr_scan(4, 32'b1101, dout);
    chk("bypass_tdo", int'(dout[3:0]), 'b1010);
    chk("bypass_strobes", cnt_cdr + cnt_sdr + cnt_udr, 0);

    // Random TMS/TDI with occasional resets
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 30, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
